// File: rtl/conv11_pkg.sv
// Shared constants and state encoding for the conv11 output controller.
package conv11_pkg;
   localparam int DATA_W       = 16;
   localparam int TILE_LEN_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;
endpackage

// File: rtl/conv11_out_fifo.sv
// Two-entry register FIFO; the head entry is visible on data_o the cycle after it is written.
module conv11_out_fifo
   import conv11_pkg::*;
#(
   parameter int WIDTH = DATA_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [1:0]       count_o
);
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Payload storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/conv11_output_ctrl.sv
// Tile output controller: gathers TILE_LEN result beats through a 2-entry FIFO,
// tags the final beat, pulses tile_done and flags dropped beats.
module conv11_output_ctrl #(
   parameter int DATA_W   = conv11_pkg::DATA_W,
   parameter int TILE_LEN = conv11_pkg::TILE_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              compute_valid,
   input  logic [DATA_W-1:0] compute_data,
   output logic              compute_ready,
   output logic              output_valid,
   output logic [DATA_W-1:0] output_data,
   input  logic              output_ready,
   output logic              output_last,
   output logic              tile_done,
   output logic              overflow_err
);
   import conv11_pkg::*;

   localparam int                CNT_W    = $clog2(TILE_LEN + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TILE_LEN - 1);
   localparam logic [CNT_W-1:0]  TILE_CNT = CNT_W'(TILE_LEN);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] push_cnt_q, push_cnt_d;
   logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
   logic             ovf_q, ovf_d;

   logic             push, pop;
   logic             fifo_full, fifo_empty;
   logic [1:0]       fifo_count;
   logic [DATA_W:0]  fifo_dout;

   assign compute_ready = (state_q == ST_STREAM) && !fifo_full && (push_cnt_q < TILE_CNT);
   assign push          = compute_valid && compute_ready;
   assign output_valid  = !fifo_empty;
   assign pop           = output_valid && output_ready;
   assign output_data   = fifo_dout[DATA_W-1:0];
   assign output_last   = output_valid && fifo_dout[DATA_W];
   assign tile_done     = (state_q == ST_DONE);
   assign overflow_err  = ovf_q;

   // The last-beat tag travels with the payload so it stays aligned through back-pressure.
   conv11_out_fifo #(.WIDTH(DATA_W + 1)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({push_cnt_q == LAST_IDX, compute_data}),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      push_cnt_d = push_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      ovf_d      = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_STREAM;
               push_cnt_d = '0;
               pop_cnt_d  = '0;
            end
         end
         ST_STREAM: begin
            if (push) push_cnt_d = push_cnt_q + CNT_W'(1);
            if (pop)  pop_cnt_d  = pop_cnt_q + CNT_W'(1);
            // Full FIFO drops the beat even if a pop frees a slot this same cycle.
            if (compute_valid && (fifo_count == 2'd2) && (push_cnt_q < TILE_CNT))
               ovf_d = 1'b1;
            if (pop && (pop_cnt_q == LAST_IDX))
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         push_cnt_q <= '0;
         pop_cnt_q  <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         push_cnt_q <= push_cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end
endmodule

// File: tb/tb_conv11_output_ctrl.sv
// Directed bench for conv11_output_ctrl: table-driven full tile plus hand sequences
// for back-pressure, overflow, mid-tile reset and a single-beat tile.
module tb_conv11_output_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start, cv, ordy;
   logic [15:0] cd;
   logic        cr, ov, olast, tdone, oerr;
   logic [15:0] od;

   logic        s1_start, s1_cv, s1_ordy;
   logic [15:0] s1_cd;
   logic        s1_cr, s1_ov, s1_olast, s1_tdone, s1_oerr;
   logic [15:0] s1_od;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   conv11_output_ctrl #(.DATA_W(16), .TILE_LEN(16)) u0 (
      .clk(clk), .rst(rst), .start(start), .compute_valid(cv), .compute_data(cd),
      .compute_ready(cr), .output_valid(ov), .output_data(od), .output_ready(ordy),
      .output_last(olast), .tile_done(tdone), .overflow_err(oerr)
   );

   conv11_output_ctrl #(.DATA_W(16), .TILE_LEN(1)) u1 (
      .clk(clk), .rst(rst), .start(s1_start), .compute_valid(s1_cv), .compute_data(s1_cd),
      .compute_ready(s1_cr), .output_valid(s1_ov), .output_data(s1_od), .output_ready(s1_ordy),
      .output_last(s1_olast), .tile_done(s1_tdone), .overflow_err(s1_oerr)
   );

   typedef struct {
      logic        start;
      logic        cv;
      logic [15:0] cd;
      logic        ordy;
      logic        e_cr;
      logic        e_ov;
      logic [15:0] e_od;
      logic        e_last;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic st, input logic v, input logic [15:0] d,
                               input logic r, input logic e_cr, input logic e_ov,
                               input logic [15:0] e_od, input logic e_last,
                               input logic e_done, input logic e_err);
      vec_t t;
      t.start = st; t.cv = v; t.cd = d; t.ordy = r;
      t.e_cr = e_cr; t.e_ov = e_ov; t.e_od = e_od;
      t.e_last = e_last; t.e_done = e_done; t.e_err = e_err;
      return t;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 20; i++) begin
         start = tbl[i].start; cv = tbl[i].cv; cd = tbl[i].cd; ordy = tbl[i].ordy;
         #1;
         $display("%s vec %0d: cr=%b ov=%b od=%h last=%b done=%b err=%b", tag, i, cr, ov, od, olast, tdone, oerr);
         chk1("tbl_cready", cr, tbl[i].e_cr);
         chk1("tbl_ovalid", ov, tbl[i].e_ov);
         if (tbl[i].e_ov) chk16("tbl_odata", od, tbl[i].e_od);
         chk1("tbl_olast", olast, tbl[i].e_last);
         chk1("tbl_tdone", tdone, tbl[i].e_done);
         chk1("tbl_oerr", oerr, tbl[i].e_err);
         step();
      end
      start = 1'b0; cv = 1'b0; ordy = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      $display("%s: cr=%b ov=%b last=%b done=%b err=%b", tag, cr, ov, olast, tdone, oerr);
      chk1("rst_cready", cr, 1'b0);
      chk1("rst_ovalid", ov, 1'b0);
      chk1("rst_olast", olast, 1'b0);
      chk1("rst_tdone", tdone, 1'b0);
      chk1("rst_oerr", oerr, 1'b0);
   endtask

   initial begin
      // Full 16-beat tile, output_ready held high: each beat one cycle after its push.
      tbl[0] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++)
         tbl[k] = mk(1'b0, 1'b1, 16'(k), 1'b1, 1'b1, (k > 1), 16'(k - 1), 1'b0, 1'b0, 1'b0);
      tbl[17] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
      tbl[18] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tbl[19] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      rst = 1'b1; start = 1'b0; cv = 1'b0; cd = '0; ordy = 1'b0;
      s1_start = 1'b0; s1_cv = 1'b0; s1_cd = '0; s1_ordy = 1'b0;
      @(negedge clk);
      step();
      #1;
      chk_reset_outputs("reset");
      chk1("u1_rst_cready", s1_cr, 1'b0);
      chk1("u1_rst_ovalid", s1_ov, 1'b0);
      rst = 1'b0;
      step();

      run_table("tile1");

      // Back-pressure: two beats fill the FIFO, head holds until released.
      start = 1'b1; step(); start = 1'b0;
      cv = 1'b1; cd = 16'hAAAA; ordy = 1'b0; #1;
      $display("bp push AAAA: cr=%b", cr);
      chk1("bp_cready0", cr, 1'b1); step();
      cd = 16'hBBBB; #1;
      $display("bp push BBBB: cr=%b ov=%b od=%h", cr, ov, od);
      chk1("bp_cready1", cr, 1'b1); chk16("bp_od1", od, 16'hAAAA); step();
      cv = 1'b0; #1;
      $display("bp full: cr=%b ov=%b od=%h", cr, ov, od);
      chk1("bp_cready_full", cr, 1'b0); chk1("bp_ov_full", ov, 1'b1); chk16("bp_hold1", od, 16'hAAAA); step();
      #1;
      $display("bp hold: od=%h", od);
      chk16("bp_hold2", od, 16'hAAAA);
      ordy = 1'b1; step();
      #1;
      $display("bp release: ov=%b od=%h", ov, od);
      chk1("bp_ov_b", ov, 1'b1); chk16("bp_od_b", od, 16'hBBBB); step();
      #1;
      $display("bp drained: ov=%b", ov);
      chk1("bp_empty", ov, 1'b0);
      ordy = 1'b0;

      // Overflow: full FIFO plus a pop in the same cycle still drops 0xCCCC.
      cv = 1'b1; cd = 16'hDDDD; step();
      cd = 16'hEEEE; #1;
      chk1("ovf_cready_pre", cr, 1'b1); step();
      cd = 16'hCCCC; ordy = 1'b1; #1;
      $display("ovf push CCCC: cr=%b ov=%b od=%h err=%b", cr, ov, od, oerr);
      chk1("ovf_cready", cr, 1'b0); chk16("ovf_od_d", od, 16'hDDDD); chk1("ovf_err_pre", oerr, 1'b0); step();
      cv = 1'b0; #1;
      $display("ovf after: ov=%b od=%h err=%b", ov, od, oerr);
      chk1("ovf_err", oerr, 1'b1); chk1("ovf_ov_e", ov, 1'b1); chk16("ovf_od_e", od, 16'hEEEE); step();
      #1;
      $display("ovf drained: ov=%b err=%b", ov, oerr);
      chk1("ovf_no_cccc", ov, 1'b0); chk1("ovf_sticky1", oerr, 1'b1); step();
      #1;
      chk1("ovf_sticky2", oerr, 1'b1);
      ordy = 1'b0;
      rst = 1'b1; step(); #1;
      chk_reset_outputs("rst after ovf");
      rst = 1'b0; step();

      // Mid-tile reset after 5 beats, then a fresh tile completes normally.
      start = 1'b1; step(); start = 1'b0;
      cv = 1'b1; ordy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cd = 16'h0100 + 16'(i);
         step();
      end
      cv = 1'b0; rst = 1'b1; #1;
      chk1("mid_ov_pre", ov, 1'b1);
      step(); #1;
      chk_reset_outputs("mid-tile rst");
      rst = 1'b0; ordy = 1'b0;
      step(); #1;
      chk1("mid_no_done", tdone, 1'b0);
      run_table("tile2");

      // Single-beat tile on the TILE_LEN=1 instance.
      s1_start = 1'b1; step(); s1_start = 1'b0;
      s1_cv = 1'b1; s1_cd = 16'h1234; s1_ordy = 1'b1; #1;
      $display("t1 push 1234: cr=%b", s1_cr);
      chk1("t1_cready", s1_cr, 1'b1); step();
      s1_cd = 16'h5678; #1;
      $display("t1 beat: cr=%b ov=%b od=%h last=%b", s1_cr, s1_ov, s1_od, s1_olast);
      chk1("t1_cready_after", s1_cr, 1'b0); chk1("t1_ov", s1_ov, 1'b1);
      chk16("t1_od", s1_od, 16'h1234); chk1("t1_last", s1_olast, 1'b1); step();
      s1_cv = 1'b0; #1;
      $display("t1 done: done=%b ov=%b err=%b", s1_tdone, s1_ov, s1_oerr);
      chk1("t1_done", s1_tdone, 1'b1); chk1("t1_ov_after", s1_ov, 1'b0); chk1("t1_err", s1_oerr, 1'b0); step();
      #1;
      $display("t1 idle: done=%b ov=%b", s1_tdone, s1_ov);
      chk1("t1_done_once", s1_tdone, 1'b0); chk1("t1_no_second", s1_ov, 1'b0); step();
      #1;
      chk1("t1_err_final", s1_oerr, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv11_output_ctrl.md
CONV11_OUTPUT_CTRL -- requirements
Module: conv11_output_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: width of one result beat.
REQ-002 Parameter TILE_LEN, default 16: result beats per tile, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that opens a tile.
REQ-006 compute_valid  input  1  compute engine presents a result beat.
REQ-007 compute_data  input  DATA_W  result beat payload.
REQ-008 compute_ready  output  1  block can accept a beat this cycle.
REQ-009 output_valid  output  1  output_data holds a valid beat for downstream.
REQ-010 output_data  output  DATA_W  beat to downstream.
REQ-011 output_ready  input  1  downstream accepts the beat this cycle.
REQ-012 output_last  output  1  marks the final beat of the tile; qualified by output_valid.
REQ-013 tile_done  output  1  one-cycle pulse after the last beat has been accepted.
REQ-014 overflow_err  output  1  sticky error flag.

Function
REQ-015 States: IDLE, STREAM, DONE; 2-bit encoding from the shared package.
REQ-016 IDLE->STREAM on start=1; push and pop counters clear to 0 on the same edge.
REQ-017 STREAM->DONE on the cycle the TILE_LEN-th beat is popped.
REQ-018 DONE drives tile_done=1 for exactly one cycle, then returns to IDLE unconditionally.
REQ-019 start outside IDLE is ignored.
REQ-020 Push = compute_valid && compute_ready; pop = output_valid && output_ready.
REQ-021 compute_ready = (state==STREAM) && (FIFO occupancy<2) && (push count<TILE_LEN); derived from registered state only.
REQ-022 Beats are held in a 2-entry FIFO in first-in, first-out order.
REQ-023 A beat pushed in cycle N appears on output_data with output_valid=1 in cycle N+1 (1-cycle latency).
REQ-024 output_data and output_last hold stable while output_valid=1 and output_ready=0.
REQ-025 Push and pop in the same cycle with occupancy 1 leave occupancy at 1 and preserve order.
REQ-026 compute_valid=1 while compute_ready=0 in STREAM, with occupancy 2, drops the beat and sets overflow_err; this holds even if a pop occurs in the same cycle.
REQ-027 compute_valid in IDLE or DONE, or after TILE_LEN pushes, is ignored and raises no error.
REQ-028 overflow_err stays set until rst.
REQ-029 output_last=1 when the head beat is push index TILE_LEN-1.
REQ-030 Push and pop counters are ceil(log2(TILE_LEN+1)) bits wide and never wrap within a tile.
REQ-031 TILE_LEN=1: the single beat carries output_last=1; DONE follows its pop.

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, FIFO flushed, counters=0, output_valid=0, output_last=0, tile_done=0, overflow_err=0, compute_ready=0.
REQ-033 rst asserted mid-tile discards buffered beats; no tile_done is issued for that tile.

Structure
REQ-034 Package conv11_pkg holds DATA_W, the TILE_LEN default, and the state encoding constants.
REQ-035 The FIFO is a sub-module, conv11_out_fifo, with push/pop/full/empty/count ports.
REQ-036 The controller FSM and counters reside in conv11_output_ctrl.

Verification
REQ-037 start, then 16 beats 0x0001..0x0010 with output_ready=1 -> 16 beats in order, each one cycle after its push; output_last only on 0x0010; tile_done one cycle after that pop.
REQ-038 output_ready=0 while pushing 0xAAAA, 0xBBBB -> compute_ready=0 with occupancy 2; output_data holds 0xAAAA; releasing output_ready yields 0xAAAA then 0xBBBB.
REQ-039 Occupancy 2, compute_valid=1 with 0xCCCC and a pop in the same cycle -> 0xCCCC never emitted; overflow_err=1 until rst.
REQ-040 rst after 5 of 16 beats -> all outputs at reset values next cycle; a new start plus 16 beats completes normally.
REQ-041 TILE_LEN=1, start, one beat 0x1234 -> output_last=1 on that beat; tile_done pulses once; a 2nd compute_valid is ignored.
